// File: rtl/cd_rx_frame_ctrl_if.sv
// Deserializer-side and buffer-RAM write signals of the receive frame controller.
// master drives the deserializer inputs; slave is the controller itself.
interface cd_rx_frame_ctrl_if #(
    parameter int unsigned IDX_W = 1
);
    logic             bus_idle;
    logic             rx_break;
    logic [7:0]       des_data;
    logic             des_data_clk;
    logic             crc_eq_zero;
    logic             force_wait_idle;
    logic             wr_en;
    logic [IDX_W+7:0] wr_addr;
    logic [7:0]       wr_data;

    modport master (
        output bus_idle, rx_break, des_data, des_data_clk, crc_eq_zero,
        input  force_wait_idle, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  bus_idle, rx_break, des_data, des_data_clk, crc_eq_zero,
        output force_wait_idle, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/cd_rx_frame_ctrl.sv
// Receive frame controller: steers deserialized frames into a ring of 256-byte buffers,
// filters on destination, checks CRC, and queues good frames for the host.
module cd_rx_frame_ctrl #(
    parameter int unsigned IDX_W   = 1,
    parameter int unsigned MAX_LEN = 251
) (
    input  logic              clk,
    input  logic              reset,
    cd_rx_frame_ctrl_if.slave des,
    input  logic [7:0]        filter,
    input  logic              promisc,
    input  logic              abort,
    output logic              rx_pend,
    output logic [IDX_W-1:0]  rx_rd_idx,
    input  logic              rx_release,
    output logic [7:0]        lost_cnt,
    output logic [7:0]        crc_err_cnt,
    output logic [7:0]        frm_err_cnt,
    output logic [7:0]        break_cnt,
    input  logic              cnt_clr
);

    localparam int unsigned    NUM_BUF = 1 << IDX_W;
    localparam logic [IDX_W:0] NumBufW = NUM_BUF[IDX_W:0];
    localparam logic [7:0]     MaxLenW = MAX_LEN[7:0];

    typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv, StDrop} state_e;

    state_e           state_q, state_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       len_q, len_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W:0]   pend_cnt_q, pend_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W+7:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             fwi_q, fwi_d;
    logic [7:0]       lost_q, crc_err_q, frm_err_q, break_q;
    logic             commit, release_ok;
    logic             inc_lost, inc_crc, inc_frm, inc_brk;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        fwi_d      = 1'b0;
        commit     = 1'b0;
        inc_lost   = 1'b0;
        inc_crc    = 1'b0;
        inc_frm    = 1'b0;
        inc_brk    = 1'b0;

        if (des.rx_break) begin
            inc_brk = 1'b1;
            state_d = StWaitIdle;
        end else begin
            unique case (state_q)
                StWaitIdle: begin
                    if (des.bus_idle) state_d = StIdle;
                end
                StIdle: begin
                    if (des.des_data_clk) begin
                        if (pend_cnt_q == NumBufW) begin
                            inc_lost = 1'b1;
                            state_d  = StDrop;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = {wr_idx_q, 8'd0};
                            wr_data_d  = des.des_data;
                            byte_cnt_d = 8'd1;
                            state_d    = StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (abort) begin
                        fwi_d   = 1'b1;
                        state_d = StWaitIdle;
                    end else if (des.bus_idle) begin
                        inc_frm = 1'b1;
                        state_d = StIdle;
                    end else if (des.des_data_clk) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = {wr_idx_q, byte_cnt_q};
                        wr_data_d  = des.des_data;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (byte_cnt_q == 8'd1) begin
                            if (!promisc && des.des_data != filter && des.des_data != 8'hFF) begin
                                state_d = StDrop;
                            end
                        end else if (byte_cnt_q == 8'd2) begin
                            len_d = des.des_data;
                            if (des.des_data > MaxLenW) begin
                                inc_frm = 1'b1;
                                fwi_d   = 1'b1;
                                state_d = StWaitIdle;
                            end
                        end else if ({1'b0, byte_cnt_q} == ({1'b0, len_q} + 9'd4)) begin
                            // Residue is only meaningful alongside the final CRC byte.
                            if (des.crc_eq_zero) commit  = 1'b1;
                            else                 inc_crc = 1'b1;
                            state_d = StWaitIdle;
                        end
                    end
                end
                StDrop: begin
                    if (abort) begin
                        fwi_d   = 1'b1;
                        state_d = StWaitIdle;
                    end else if (des.bus_idle) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StWaitIdle;
            endcase
        end
    end

    // Pending queue: commit pushes at wr_idx, release pops at rd_idx.
    always_comb begin
        release_ok = rx_release && (pend_cnt_q != '0);
        wr_idx_d   = commit ? wr_idx_q + 1'b1 : wr_idx_q;
        rd_idx_d   = release_ok ? rd_idx_q + 1'b1 : rd_idx_q;
        pend_cnt_d = pend_cnt_q;
        if (commit && !release_ok)      pend_cnt_d = pend_cnt_q + 1'b1;
        else if (!commit && release_ok) pend_cnt_d = pend_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StWaitIdle;
            byte_cnt_q <= '0;
            len_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            pend_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            fwi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            pend_cnt_q <= pend_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            fwi_q      <= fwi_d;
        end
    end

    // Saturating event counters; cnt_clr beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            lost_q    <= '0;
            crc_err_q <= '0;
            frm_err_q <= '0;
            break_q   <= '0;
        end else begin
            if (inc_lost && lost_q != 8'hFF)    lost_q    <= lost_q + 8'd1;
            if (inc_crc && crc_err_q != 8'hFF)  crc_err_q <= crc_err_q + 8'd1;
            if (inc_frm && frm_err_q != 8'hFF)  frm_err_q <= frm_err_q + 8'd1;
            if (inc_brk && break_q != 8'hFF)    break_q   <= break_q + 8'd1;
        end
    end

    assign des.wr_en           = wr_en_q;
    assign des.wr_addr         = wr_addr_q;
    assign des.wr_data         = wr_data_q;
    assign des.force_wait_idle = fwi_q;
    assign rx_pend             = (pend_cnt_q != '0);
    assign rx_rd_idx           = rd_idx_q;
    assign lost_cnt            = lost_q;
    assign crc_err_cnt         = crc_err_q;
    assign frm_err_cnt         = frm_err_q;
    assign break_cnt           = break_q;

endmodule

// File: tb/tb_cd_rx_frame_ctrl.sv
// Bench for cd_rx_frame_ctrl: expected RAM writes are queued as bytes are driven and
// popped when wr_en appears; status and counters are checked against fixed expectations.
module tb_cd_rx_frame_ctrl;
    localparam int unsigned IDX_W = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       filter;
    logic             promisc;
    logic             abort;
    logic             rx_pend;
    logic [IDX_W-1:0] rx_rd_idx;
    logic             rx_release;
    logic [7:0]       lost_cnt, crc_err_cnt, frm_err_cnt, break_cnt;
    logic             cnt_clr;

    int errors = 0;
    int checks = 0;
    int fwi_cnt = 0;
    logic [IDX_W+15:0] exp_q[$];

    cd_rx_frame_ctrl_if #(.IDX_W(IDX_W)) ifc ();

    cd_rx_frame_ctrl #(.IDX_W(IDX_W), .MAX_LEN(251)) dut (
        .clk        (clk),
        .reset      (reset),
        .des        (ifc.slave),
        .filter     (filter),
        .promisc    (promisc),
        .abort      (abort),
        .rx_pend    (rx_pend),
        .rx_rd_idx  (rx_rd_idx),
        .rx_release (rx_release),
        .lost_cnt   (lost_cnt),
        .crc_err_cnt(crc_err_cnt),
        .frm_err_cnt(frm_err_cnt),
        .break_cnt  (break_cnt),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ifc.force_wait_idle === 1'b1) fwi_cnt++;
        if (ifc.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {ifc.wr_addr, ifc.wr_data}, 32'hFFFF_FFFF);
            end else begin
                logic [IDX_W+15:0] e;
                e = exp_q.pop_front();
                check("wr", {ifc.wr_addr, ifc.wr_data}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        ifc.bus_idle = 1'b1;
        tick();
        tick();
    endtask

    // Drives n_send frame bytes; the first n_wr are expected at {idx, byte}.
    task automatic send_frame(input logic [7:0] dst, input logic [7:0] len, input int n_send,
                              input int n_wr, input int idx, input bit crc_ok,
                              input bit rel_last);
        logic [7:0]       b;
        logic [IDX_W-1:0] ix;
        ix = idx[IDX_W-1:0];
        ifc.bus_idle = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            if (i == 0)      b = 8'h00;
            else if (i == 1) b = dst;
            else if (i == 2) b = len;
            else             b = 8'hA7 + 8'(i);
            ifc.des_data     = b;
            ifc.des_data_clk = 1'b1;
            ifc.crc_eq_zero  = (i == n_send - 1) ? crc_ok : 1'b0;
            rx_release       = rel_last && (i == n_send - 1);
            if (i < n_wr) exp_q.push_back({ix, 8'(i), b});
            tick();
            ifc.des_data_clk = 1'b0;
            ifc.crc_eq_zero  = 1'b0;
            rx_release       = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_release();
        rx_release = 1'b1;
        tick();
        rx_release = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input logic [7:0] l, input logic [7:0] c,
                              input logic [7:0] f, input logic [7:0] b);
        check({tag, "_lost"}, lost_cnt, l);
        check({tag, "_crc"}, crc_err_cnt, c);
        check({tag, "_frm"}, frm_err_cnt, f);
        check({tag, "_brk"}, break_cnt, b);
    endtask

    initial begin
        reset = 1'b1;
        filter = 8'h01;
        promisc = 1'b0;
        abort = 1'b0;
        rx_release = 1'b0;
        cnt_clr = 1'b0;
        ifc.bus_idle = 1'b0;
        ifc.rx_break = 1'b0;
        ifc.des_data = 8'h00;
        ifc.des_data_clk = 1'b0;
        ifc.crc_eq_zero = 1'b0;
        tick();
        tick();
        check("rst_pend", rx_pend, 0);
        check("rst_rd", rx_rd_idx, 0);
        check("rst_wr_en", ifc.wr_en, 0);
        check("rst_fwi", ifc.force_wait_idle, 0);
        check_cnts("rst", 0, 0, 0, 0);
        reset = 1'b0;
        // WAIT_IDLE ignores bytes until bus_idle
        send_frame(8'h01, 8'd2, 7, 0, 0, 1'b1, 1'b0);
        check("waitidle_pend", rx_pend, 0);
        idle_gap();

        // 1: good frame
        send_frame(8'h01, 8'd2, 7, 7, 0, 1'b1, 1'b0);
        idle_gap();
        check("good_pend", rx_pend, 1);
        check("good_rd", rx_rd_idx, 0);
        check_cnts("good", 0, 0, 0, 0);
        check("good_drain", exp_q.size(), 0);
        pulse_release();
        check("rel1_pend", rx_pend, 0);
        check("rel1_rd", rx_rd_idx, 1);

        // 2: filtered, then broadcast
        send_frame(8'h05, 8'd2, 7, 2, 1, 1'b1, 1'b0);
        idle_gap();
        check("filt_pend", rx_pend, 0);
        check_cnts("filt", 0, 0, 0, 0);
        send_frame(8'hFF, 8'd2, 7, 7, 1, 1'b1, 1'b0);
        idle_gap();
        check("bcast_pend", rx_pend, 1);
        check("bcast_rd", rx_rd_idx, 1);
        pulse_release();
        check("rel2_rd", rx_rd_idx, 0);

        // 3: bad CRC, then oversize len
        send_frame(8'h01, 8'd2, 7, 7, 0, 1'b0, 1'b0);
        idle_gap();
        check("crc_pend", rx_pend, 0);
        check_cnts("crc", 0, 1, 0, 0);
        send_frame(8'h01, 8'hFC, 5, 3, 0, 1'b1, 1'b0);
        idle_gap();
        check_cnts("len", 0, 1, 1, 0);
        check("len_fwi", fwi_cnt, 1);
        send_frame(8'h01, 8'd251, 3, 3, 0, 1'b1, 1'b0);
        idle_gap();
        check_cnts("maxlen_trunc", 0, 1, 2, 0);
        check("maxlen_fwi", fwi_cnt, 1);

        // 4: ring full, lost frame, simultaneous commit and release
        send_frame(8'h01, 8'd2, 7, 7, 0, 1'b1, 1'b0);
        idle_gap();
        send_frame(8'h01, 8'd0, 5, 5, 1, 1'b1, 1'b0);
        idle_gap();
        send_frame(8'h01, 8'd2, 7, 0, 0, 1'b1, 1'b0);
        idle_gap();
        check_cnts("lost", 1, 1, 2, 0);
        check("full_pend", rx_pend, 1);
        check("full_rd", rx_rd_idx, 0);
        pulse_release();
        check("rel3_rd", rx_rd_idx, 1);
        send_frame(8'h01, 8'd2, 7, 7, 0, 1'b1, 1'b1);
        idle_gap();
        check("cr_pend", rx_pend, 1);
        check("cr_rd", rx_rd_idx, 0);
        pulse_release();
        check("rel4_pend", rx_pend, 0);
        check("rel4_rd", rx_rd_idx, 1);
        pulse_release();
        check("rel_empty_rd", rx_rd_idx, 1);

        // 5: break mid-payload, ignored follow-on frame, truncation
        send_frame(8'h01, 8'd4, 5, 5, 1, 1'b1, 1'b0);
        ifc.rx_break = 1'b1;
        tick();
        ifc.rx_break = 1'b0;
        send_frame(8'h01, 8'd2, 7, 0, 1, 1'b1, 1'b0);
        check_cnts("brk", 1, 1, 2, 1);
        check("brk_pend", rx_pend, 0);
        idle_gap();
        send_frame(8'h01, 8'd4, 5, 5, 1, 1'b1, 1'b0);
        idle_gap();
        check_cnts("trunc", 1, 1, 3, 1);
        check("trunc_pend", rx_pend, 0);

        // abort mid-frame: one force_wait_idle, no counter change
        send_frame(8'h01, 8'd4, 4, 4, 1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_fwi", fwi_cnt, 2);
        check_cnts("abort", 1, 1, 3, 1);
        idle_gap();
        check("abort_drain", exp_q.size(), 0);

        // 6: reset mid-frame
        send_frame(8'h01, 8'd4, 4, 4, 1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cnts("rst2", 0, 0, 0, 0);
        check("rst2_pend", rx_pend, 0);
        check("rst2_rd", rx_rd_idx, 0);
        check("rst2_wr_en", ifc.wr_en, 0);
        // back in WAIT_IDLE: this frame must be ignored
        send_frame(8'h01, 8'd2, 7, 0, 0, 1'b1, 1'b0);
        check("rst2_ign_pend", rx_pend, 0);

        ifc.rx_break = 1'b1;
        tick();
        ifc.rx_break = 1'b0;
        check("brk_one", break_cnt, 1);
        ifc.rx_break = 1'b1;
        cnt_clr = 1'b1;
        tick();
        ifc.rx_break = 1'b0;
        cnt_clr = 1'b0;
        check("clr_wins", break_cnt, 0);
        for (int i = 0; i < 260; i++) begin
            ifc.rx_break = 1'b1;
            tick();
            ifc.rx_break = 1'b0;
            tick();
        end
        check("brk_sat", break_cnt, 8'hFF);
        check("drain_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
